tdm_mux_tx: RTL and testbench
=============================

Name: tdm_mux_tx

Overview:
- Time-division multiplexing transmitter: captures an N_CH-bit parallel word and sends it one bit per slot on a single serial line.
- Drives the slot select alongside the data, so a downstream 1-to-N demultiplexer can route each bit back to its lane.
- Sits at the transmit end of the lane-select link; the demux is the receive end.

Parameters:
- SEL_W, 3, select width; N_CH = 2**SEL_W lanes (default 8).
- HOLD, 1, clock cycles each slot is held on the line; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- En  input  1  block enable; 0 aborts any frame and forces outputs to 0.
- load_valid  input  1  producer has a word on IN.
- load_ready  output  1  block can accept a word this cycle.
- IN  input  N_CH  parallel word; bit i is sent in slot i.
- OUT  output  1  serial data bit for the current slot.
- S  output  SEL_W  current slot index; receiver routes OUT to lane S.
- slot_valid  output  1  OUT/S carry a live slot.
- frame_start  output  1  first cycle of slot 0 of a frame.
- frame_done  output  1  one-cycle pulse after the last cycle of slot N_CH-1.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; OUT, S, slot_valid, frame_start, frame_done = 0; shadow register, slot counter and hold counter = 0. Reset overrides everything, including a frame in progress.
- Registered outputs: OUT, S, slot_valid, frame_start, frame_done. Combinational output: load_ready.
- load_ready = En && (state==IDLE || (state==SEND && slot==N_CH-1 && hold_cnt==HOLD-1)).
- Transfer: occurs when load_valid && load_ready at a clk edge. IN is captured into the shadow register; slot=0, hold_cnt=0, state=SEND.
- Latency: a word captured at edge k drives slot 0 in the cycle after edge k.
- State IDLE: slot_valid=0, OUT=0, S=0. Stays in IDLE until a transfer.
- State SEND, each cycle:
  - slot_valid=1, S=slot, OUT=shadow[slot].
  - frame_start=1 only when slot==0 && hold_cnt==0.
  - hold_cnt increments. When hold_cnt==HOLD-1 it wraps to 0 and slot increments.
- End of frame (slot==N_CH-1 && hold_cnt==HOLD-1):
  - frame_done pulses in the following cycle.
  - If a transfer occurs on that same edge, the new word starts at slot 0 with no gap (back-to-back), and frame_start and frame_done are both 1 in that cycle.
  - Otherwise go to IDLE; slot_valid=0 in the following cycle.
- load_valid during SEND, except in the final cycle: ignored (load_ready=0); the producer must hold the word.
- En=0 (any state): next edge forces IDLE and clears all outputs. The shadow word is discarded, no frame_done is issued, and load_ready=0. Resuming En returns to IDLE behaviour.
- IN changes after capture have no effect on the frame in progress.
- HOLD=1: slot advances every cycle; a frame is N_CH cycles.
- Frame length: N_CH*HOLD cycles. Throughput: one word per N_CH*HOLD cycles when back-to-back.

Test Plan:
1. Defaults, IN=8'b1010_0110, one transfer, En=1 -> over 8 cycles S=0..7 with OUT=0,1,1,0,0,1,0,1; frame_start only in the S=0 cycle; frame_done pulses in the 9th cycle with slot_valid=0 there.
2. Back-to-back: IN=8'hFF then 8'h00, load_valid held high -> load_ready high only in IDLE and in the S=7 cycle; 16 contiguous slot_valid cycles (OUT eight 1s then eight 0s); in the 9th cycle frame_start=1 and frame_done=1 together.
3. HOLD=3, IN=8'h81 -> each S value lasts 3 cycles; OUT=1 only for S=0 and S=7; frame is 24 cycles; frame_done pulses once, in cycle 25.
4. En dropped during slot 4 of IN=8'h5A -> next cycle OUT=0, S=0, slot_valid=0; no frame_done; after En=1, a new transfer of 8'h01 sends OUT=1 only in slot 0.
5. rst_n=0 for one cycle during slot 2 -> all outputs 0 the next cycle, state IDLE, load_ready=1 once rst_n=1 and En=1.
6. En=0 with load_valid=1 and IN=8'hC3 -> load_ready=0, no capture, outputs remain 0 indefinitely.

Source files
------------

// File: rtl/tdm_mux_tx.sv
// -----------------------------------------------------------------------------
// tdm_mux_tx
// Time-division multiplexing transmitter. A parallel word of N_CH = 2**SEL_W
// bits is captured into a shadow register. It is then sent one bit per slot on
// a single serial line. Each slot is held for HOLD clock cycles. The slot index
// is driven alongside the data, so a downstream 1-to-N demux can route each
// bit back to its lane.
//
// Parameters
//   SEL_W        select width; N_CH = 2**SEL_W lanes
//   HOLD         cycles each slot stays on the line (legal 1..255)
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   En           block enable; 0 aborts any frame and zeroes the outputs
//   load_valid   producer offers a word on IN
//   load_ready   block accepts a word this cycle (combinational)
//   IN           parallel word; bit i is sent in slot i
//   OUT          serial data bit of the current slot (registered)
//   S            current slot index (registered)
//   slot_valid   OUT/S carry a live slot (registered)
//   frame_start  first cycle of slot 0 of a frame (registered)
//   frame_done   one-cycle pulse after the last cycle of slot N_CH-1 (registered)
// -----------------------------------------------------------------------------
module tdm_mux_tx #(
    parameter int SEL_W = 3,
    parameter int HOLD  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  En,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [2**SEL_W-1:0]   IN,
    output logic                  OUT,
    output logic [SEL_W-1:0]      S,
    output logic                  slot_valid,
    output logic                  frame_start,
    output logic                  frame_done
);

    localparam int N_CH = 2**SEL_W;
    localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(N_CH - 1);
    localparam logic [7:0]       HOLD_LAST = 8'(HOLD - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   shadow_q, shadow_d;
    logic [SEL_W-1:0]  slot_q, slot_d;
    logic [7:0]        hold_q, hold_d;

    logic              out_q, out_d;
    logic [SEL_W-1:0]  s_q, s_d;
    logic              slot_valid_q, slot_valid_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q, frame_done_d;

    logic              end_of_frame;
    logic              xfer;

    // The last cycle of the last slot is the only point during SEND at which a
    // new word can be taken. Accepting it there gives back-to-back frames.
    assign end_of_frame = (state_q == SEND) && (slot_q == SLOT_LAST) && (hold_q == HOLD_LAST);
    assign load_ready   = En && ((state_q == IDLE) || end_of_frame);
    assign xfer         = load_valid && load_ready;

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d      = state_q;
        shadow_d     = shadow_q;
        slot_d       = slot_q;
        hold_d       = hold_q;
        frame_done_d = 1'b0;

        if (!En) begin
            // Abort: the shadow word is discarded and no frame_done is issued.
            state_d  = IDLE;
            shadow_d = '0;
            slot_d   = '0;
            hold_d   = '0;
        end else if (xfer) begin
            state_d      = SEND;
            shadow_d     = IN;
            slot_d       = '0;
            hold_d       = '0;
            frame_done_d = end_of_frame;
        end else if (state_q == SEND) begin
            if (end_of_frame) begin
                state_d      = IDLE;
                slot_d       = '0;
                hold_d       = '0;
                frame_done_d = 1'b1;
            end else if (hold_q == HOLD_LAST) begin
                hold_d = '0;
                slot_d = slot_q + SEL_W'(1);
            end else begin
                hold_d = hold_q + 8'd1;
            end
        end

        // The output registers are loaded from the next state. The slot that
        // state_d describes therefore appears on the line in the cycle right
        // after the edge, which gives one-cycle capture-to-slot-0 latency.
        slot_valid_d  = (state_d == SEND);
        s_d           = slot_valid_d ? slot_d : '0;
        out_d         = slot_valid_d ? shadow_d[slot_d] : 1'b0;
        frame_start_d = slot_valid_d && (slot_d == '0) && (hold_d == '0);
    end

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset; the shadow register is reset too, because
        // it is a single word and not a memory array.
        if (!rst_n) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            slot_q        <= '0;
            hold_q        <= '0;
            out_q         <= 1'b0;
            s_q           <= '0;
            slot_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so all registers update together.
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            slot_q        <= slot_d;
            hold_q        <= hold_d;
            out_q         <= out_d;
            s_q           <= s_d;
            slot_valid_q  <= slot_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign OUT         = out_q;
    assign S           = s_q;
    assign slot_valid  = slot_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_tdm_mux_tx.sv
// -----------------------------------------------------------------------------
// tb_tdm_mux_tx
// Two transmitters share one stimulus stream: instance 0 uses HOLD=1 and
// instance 1 uses HOLD=3. The reference model is kept per instance. It tracks
// how many slot cycles of the current frame remain. On each accepted word it
// expands the word into its full list of per-cycle (OUT, S, frame_start)
// records. A monitor pops one record whenever an instance shows slot_valid.
// -----------------------------------------------------------------------------
module tb_tdm_mux_tx;

    typedef struct packed {
        logic       o;
        logic [2:0] s;
        logic       st;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic En = 1'b0;
    logic load_valid = 1'b0;
    logic [7:0] IN = '0;

    logic [1:0]      rdy_w, out_w, sv_w, fs_w, fd_w;
    logic [1:0][2:0] s_w;

    always #5 clk = ~clk;

    tdm_mux_tx #(.SEL_W(3), .HOLD(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .En(En), .load_valid(load_valid),
        .load_ready(rdy_w[0]), .IN(IN), .OUT(out_w[0]), .S(s_w[0]),
        .slot_valid(sv_w[0]), .frame_start(fs_w[0]), .frame_done(fd_w[0])
    );

    tdm_mux_tx #(.SEL_W(3), .HOLD(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .En(En), .load_valid(load_valid),
        .load_ready(rdy_w[1]), .IN(IN), .OUT(out_w[1]), .S(s_w[1]),
        .slot_valid(sv_w[1]), .frame_start(fs_w[1]), .frame_done(fd_w[1])
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;
    logic chk_en = 1'b0;

    // Reference model state.
    int   hold_v [2] = '{1, 3};
    int   left [2]   = '{0, 0};      // slot cycles left in the frame, incl. the one shown now
    logic exp_done [2] = '{1'b0, 1'b0};
    rec_t q0 [$];
    rec_t q1 [$];

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (hold=%0d) at %0t: got %0h expected %0h", name, hold_v[d], $time, act, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic rec_t qpop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Expand a word into its frame: N_CH slots, each repeated HOLD times.
    task automatic push_frame(input int d, input logic [7:0] w);
        rec_t r;
        for (int s = 0; s < 8; s++) begin
            for (int h = 0; h < hold_v[d]; h++) begin
                r.o  = w[s];
                r.s  = 3'(s);
                r.st = (s == 0) && (h == 0);
                if (d == 0) q0.push_back(r); else q1.push_back(r);
            end
        end
    endtask

    // One clock cycle. Drive at negedge, check load_ready, and resolve which
    // instances accept a word. Then advance the model at the posedge.
    task automatic step(input logic en, input logic rn, input logic lv, input logic [7:0] w);
        logic xfer [2];
        logic exp_rdy;
        @(negedge clk);
        En = en;
        rst_n = rn;
        load_valid = lv;
        IN = w;
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_rdy = en && (left[d] <= 1);
            if (chk_en) check("load_ready", d, 32'(rdy_w[d]), 32'(exp_rdy));
            xfer[d] = lv && exp_rdy && rn;
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rn || !en) begin
                left[d] = 0;
                exp_done[d] = 1'b0;
                if (d == 0) q0.delete(); else q1.delete();
            end else begin
                exp_done[d] = (left[d] == 1);
                if (left[d] > 0) left[d]--;
                if (xfer[d]) begin
                    push_frame(d, w);
                    left[d] = 8 * hold_v[d];
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
    endtask

    // Monitor: compares per cycle, popping an expected record on each live slot.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                rec_t r;
                check("slot_valid", d, 32'(sv_w[d]), 32'(left[d] != 0));
                check("frame_done", d, 32'(fd_w[d]), 32'(exp_done[d]));
                if (sv_w[d] && qsize(d) > 0) begin
                    r = qpop(d);
                    check("OUT", d, 32'(out_w[d]), 32'(r.o));
                    check("S", d, 32'(s_w[d]), 32'(r.s));
                    check("frame_start", d, 32'(fs_w[d]), 32'(r.st));
                end else if (!sv_w[d]) begin
                    check("OUT_idle", d, 32'(out_w[d]), 32'd0);
                    check("S_idle", d, 32'(s_w[d]), 32'd0);
                    check("frame_start_idle", d, 32'(fs_w[d]), 32'd0);
                end
            end
        end
    end

    initial begin
        // Reset.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk_en = 1'b1;
        mon_en = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // Single frame of 1010_0110.
        step(1'b1, 1'b1, 1'b1, 8'hA6);
        idle(30);

        // Back-to-back: FF then 00 with load_valid held high.
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b1, 8'h00);
        idle(60);

        // 8'h81 (the HOLD=3 instance shows the stretched frame).
        step(1'b1, 1'b1, 1'b1, 8'h81);
        idle(30);

        // En dropped mid-frame, then a fresh word 8'h01.
        step(1'b1, 1'b1, 1'b1, 8'h5A);
        idle(4);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        idle(2);
        step(1'b1, 1'b1, 1'b1, 8'h01);
        idle(30);

        // Reset pulse during slot 2.
        step(1'b1, 1'b1, 1'b1, 8'h3C);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        idle(5);

        // Disabled block with a pending offer.
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 8'hC3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 24) != 0,
                 ($urandom % 80) != 0,
                 ($urandom % 3) != 0,
                 8'($urandom_range(255)));
        end

        idle(40);
        @(negedge clk);
        #2;
        for (int d = 0; d < 2; d++) check("drain", d, 32'(qsize(d)), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
